// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus shared by the two requesters and the regfile write port.
// The arbiter sits on the slave side; requesters and the regfile sit on the master side.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATAWIDTH = 32
) ();

    // ALU writeback requester
    logic                 req0_valid;
    logic                 req0_ready;
    logic [4:0]           req0_reg;
    logic [DATAWIDTH-1:0] req0_data;

    // Load/memory return requester
    logic                 req1_valid;
    logic                 req1_ready;
    logic [4:0]           req1_reg;
    logic [DATAWIDTH-1:0] req1_data;

    // Registered regfile write port
    logic                 write;
    logic [4:0]           writeReg;
    logic [DATAWIDTH-1:0] writeData;
    logic                 grant_id;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  write, writeReg, writeData, grant_id
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output write, writeReg, writeData, grant_id
    );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between the ALU
// writeback path (req0) and the load return path (req1). The current owner may
// keep the port for up to MAX_BURST consecutive grants while the other waits.
// The grant is combinational; the write port is driven from registers.
module regfile_wb_arbiter #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned MAX_BURST = 4,
    parameter bit          DROP_R0   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    regfile_wb_arbiter_if.slave   io_bus
);

    localparam int unsigned      CntW   = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);
    localparam logic [CntW-1:0] OneCnt = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e                 r_state;
    logic [CntW-1:0]        r_burst_cnt;
    logic                   r_last_grant;
    logic                   r_write;
    logic [4:0]             r_write_reg;
    logic [DATAWIDTH-1:0]   r_write_data;
    logic                   r_grant_id;

    state_e                 w_state_next;
    logic [CntW-1:0]        w_burst_next;
    logic                   w_last_next;
    logic                   w_grant_valid;
    logic                   w_grant_id;
    logic                   w_both;
    logic [4:0]             w_sel_reg;
    logic [DATAWIDTH-1:0]   w_sel_data;
    logic                   w_issue;

    // Grant decision and next arbitration state
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        w_state_next  = StIdle;
        w_burst_next  = '0;
        w_last_next   = r_last_grant;
        w_both        = io_bus.req0_valid & io_bus.req1_valid;

        // Nothing is acknowledged while reset is held
        if (i_resetn && (io_bus.req0_valid || io_bus.req1_valid)) begin
            w_grant_valid = 1'b1;
            if (!w_both) begin
                w_grant_id = io_bus.req1_valid;
            end else begin
                case (r_state)
                    StOwn0:  w_grant_id = (r_burst_cnt < MaxCnt) ? 1'b0 : 1'b1;
                    StOwn1:  w_grant_id = (r_burst_cnt < MaxCnt) ? 1'b1 : 1'b0;
                    default: w_grant_id = ~r_last_grant;
                endcase
            end
        end

        if (w_grant_valid) begin
            w_state_next = w_grant_id ? StOwn1 : StOwn0;
            w_last_next  = w_grant_id;
            // Same owner as last cycle extends the run; otherwise a new run starts
            if (r_state == w_state_next) begin
                w_burst_next = (r_burst_cnt == MaxCnt) ? MaxCnt : r_burst_cnt + OneCnt;
            end else begin
                w_burst_next = OneCnt;
            end
        end
    end

    // Selected payload and whether it actually reaches the regfile
    always_comb begin
        w_sel_reg  = w_grant_id ? io_bus.req1_reg  : io_bus.req0_reg;
        w_sel_data = w_grant_id ? io_bus.req1_data : io_bus.req0_data;
        // Register 0 writes are swallowed: handshake completes but no write issues
        w_issue    = w_grant_valid && !(DROP_R0 && (w_sel_reg == 5'd0));
    end

    assign io_bus.req0_ready = w_grant_valid & ~w_grant_id;
    assign io_bus.req1_ready = w_grant_valid &  w_grant_id;

    // Arbitration state registers
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state      <= StIdle;
            r_burst_cnt  <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_burst_cnt  <= w_burst_next;
            r_last_grant <= w_last_next;
        end
    end

    // Registered write port; address/data hold when no write issues
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_write      <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_grant_id   <= 1'b0;
        end else begin
            r_write <= w_issue;
            if (w_issue) begin
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
                r_grant_id   <= w_grant_id;
            end
        end
    end

    assign io_bus.write     = r_write;
    assign io_bus.writeReg  = r_write_reg;
    assign io_bus.writeData = r_write_data;
    assign io_bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: two instances (register-0 drop on and off) share
// one stimulus stream and are compared every cycle against a grant-history model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATAWIDTH(DW)) bus0 ();
    regfile_wb_arbiter_if #(.DATAWIDTH(DW)) bus1 ();

    regfile_wb_arbiter #(
        .DATAWIDTH (DW),
        .MAX_BURST (MB),
        .DROP_R0   (1'b1)
    ) u_dut_drop (
        .i_clk    (clk),
        .i_resetn (resetn),
        .io_bus   (bus0.slave)
    );

    regfile_wb_arbiter #(
        .DATAWIDTH (DW),
        .MAX_BURST (MB),
        .DROP_R0   (1'b0)
    ) u_dut_keep (
        .i_clk    (clk),
        .i_resetn (resetn),
        .io_bus   (bus1.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: history of recent grant outcomes (-1 = no grant) plus last granted id
    int          m_hist[$];
    bit          m_last;
    logic        m_wr   [2];
    logic [4:0]  m_reg  [2];
    logic [31:0] m_data [2];
    logic        m_gid  [2];

    // Readies seen on the drop instance during the latest step
    logic obs_r0;
    logic obs_r1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Grant from the rules: lone requester wins; on a tie the current owner keeps
    // the port until it has MAX_BURST grants in a row, and from idle the one not
    // granted last time wins.
    task automatic model_grant(input bit rst_n, input bit v0, input bit v1,
                               output bit gv, output bit gid);
        int owner;
        int run;
        gv  = 1'b0;
        gid = 1'b0;
        if (rst_n && (v0 || v1)) begin
            gv = 1'b1;
            if (v0 && !v1) begin
                gid = 1'b0;
            end else if (v1 && !v0) begin
                gid = 1'b1;
            end else begin
                owner = (m_hist.size() == 0) ? -1 : m_hist[$];
                if (owner < 0) begin
                    gid = ~m_last;
                end else begin
                    run = 0;
                    for (int i = m_hist.size() - 1; i >= 0; i--) begin
                        if (m_hist[i] != owner) break;
                        run++;
                    end
                    gid = (run < int'(MB)) ? owner[0] : ~owner[0];
                end
            end
        end
    endtask

    task automatic check_port(input string name, input int k, input logic wr,
                              input logic [4:0] wreg, input logic [31:0] wdata,
                              input logic gid);
        check_val({name, "_write"}, wr, m_wr[k]);
        check_val({name, "_wreg"}, wreg, m_reg[k]);
        check_val({name, "_wdata"}, wdata, m_data[k]);
        if (m_wr[k]) check_val({name, "_gid"}, gid, m_gid[k]);
    endtask

    // One clock cycle: drive, check readies, clock, update model, check write port
    task automatic step(input bit rst_n,
                        input bit v0, input logic [4:0] g0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] g1, input logic [31:0] d1,
                        output bit gv, output bit gid);
        logic [4:0]  sreg;
        logic [31:0] sdata;
        @(negedge clk);
        resetn          = rst_n;
        bus0.req0_valid = v0; bus0.req0_reg = g0; bus0.req0_data = d0;
        bus0.req1_valid = v1; bus0.req1_reg = g1; bus0.req1_data = d1;
        bus1.req0_valid = v0; bus1.req0_reg = g0; bus1.req0_data = d0;
        bus1.req1_valid = v1; bus1.req1_reg = g1; bus1.req1_data = d1;
        #1;
        model_grant(rst_n, v0, v1, gv, gid);
        obs_r0 = bus0.req0_ready;
        obs_r1 = bus0.req1_ready;
        check_val("drop_ready0", bus0.req0_ready, gv && !gid);
        check_val("drop_ready1", bus0.req1_ready, gv && gid);
        check_val("keep_ready0", bus1.req0_ready, gv && !gid);
        check_val("keep_ready1", bus1.req1_ready, gv && gid);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_hist.delete();
            m_last = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_wr[k] = 1'b0; m_reg[k] = '0; m_data[k] = '0; m_gid[k] = 1'b0;
            end
        end else begin
            if (gv) begin
                m_hist.push_back(int'(gid));
                m_last = gid;
                sreg   = gid ? g1 : g0;
                sdata  = gid ? d1 : d0;
                for (int k = 0; k < 2; k++) begin
                    if (k == 0 && sreg == 5'd0) begin
                        m_wr[k] = 1'b0;
                    end else begin
                        m_wr[k] = 1'b1; m_reg[k] = sreg; m_data[k] = sdata; m_gid[k] = gid;
                    end
                end
            end else begin
                m_hist.push_back(-1);
                m_wr[0] = 1'b0;
                m_wr[1] = 1'b0;
            end
            while (m_hist.size() > int'(MB) + 1) void'(m_hist.pop_front());
        end
        check_port("drop", 0, bus0.write, bus0.writeReg, bus0.writeData, bus0.grant_id);
        check_port("keep", 1, bus1.write, bus1.writeReg, bus1.writeData, bus1.grant_id);
    endtask

    bit          gv;
    bit          gid;
    logic        tie_seq [5];
    int          granted_at;
    int          n_writes;
    bit          p0v, p1v;
    logic [4:0]  p0r, p1r;
    logic [31:0] p0d, p1d;

    initial begin
        resetn = 1'b0;
        bus0.req0_valid = 1'b0; bus0.req0_reg = '0; bus0.req0_data = '0;
        bus0.req1_valid = 1'b0; bus0.req1_reg = '0; bus0.req1_data = '0;
        bus1.req0_valid = 1'b0; bus1.req0_reg = '0; bus1.req0_data = '0;
        bus1.req1_valid = 1'b0; bus1.req1_reg = '0; bus1.req1_data = '0;
        m_last = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = 1'b0; m_reg[k] = '0; m_data[k] = '0; m_gid[k] = 1'b0;
        end

        // Reset held two cycles with both requesting
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, gv, gid);
            check_val("rst_ready0", obs_r0, 1'b0);
            check_val("rst_ready1", obs_r1, 1'b0);
            check_val("rst_write", bus0.write, 1'b0);
            check_val("rst_wreg", bus0.writeReg, 5'd0);
            check_val("rst_wdata", bus0.writeData, 32'd0);
        end

        // Single ALU writeback
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, gv, gid);
        check_val("single_ready", obs_r0, 1'b1);
        check_val("single_write", bus0.write, 1'b1);
        check_val("single_wreg", bus0.writeReg, 5'd5);
        check_val("single_wdata", bus0.writeData, 32'hDEADBEEF);
        check_val("single_gid", bus0.grant_id, 1'b0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, gv, gid);
        check_val("single_after", bus0.write, 1'b0);
        check_val("single_hold", bus0.writeData, 32'hDEADBEEF);

        // Tie from idle after reset: four to req0 then one to req1
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, gv, gid);
        tie_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 5'(i + 1), 32'(i + 100), 1'b1, 5'd9, 32'h900, gv, gid);
            check_val("tie_gid", bus0.grant_id, tie_seq[i]);
        end

        // Starvation: req0 streams, req1 arrives at cycle 2
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, gv, gid);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, gv, gid);
        granted_at = -100;
        n_writes   = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b1, 5'd7, 32'(c), (c >= 2) && (granted_at < 0), 5'd8, 32'hBEEF,
                 gv, gid);
            check_val("starve_mutex", obs_r0 & obs_r1, 1'b0);
            if (obs_r1 && granted_at < 0) granted_at = c;
            if (bus0.write) n_writes++;
        end
        check_val("starve_bound", (granted_at >= 2) && (granted_at - 2 <= int'(MB)), 1'b1);
        check_val("starve_tput", n_writes, 8);

        // Register 0 write from the load path
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, gv, gid);
        check_val("r0_ready", obs_r1, 1'b1);
        check_val("r0_drop_write", bus0.write, 1'b0);
        check_val("r0_keep_write", bus1.write, 1'b1);
        check_val("r0_keep_wreg", bus1.writeReg, 5'd0);
        check_val("r0_keep_wdata", bus1.writeData, 32'h1234);

        // Reset right after a transfer discards the pending write
        step(1'b1, 1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 32'd0, gv, gid);
        check_val("mid_write", bus0.write, 1'b1);
        step(1'b0, 1'b1, 5'd7, 32'hA6, 1'b1, 5'd2, 32'hB6, gv, gid);
        check_val("mid_rst_write", bus0.write, 1'b0);
        step(1'b1, 1'b1, 5'd7, 32'hA6, 1'b1, 5'd2, 32'hB6, gv, gid);
        check_val("mid_tie_req0", obs_r0, 1'b1);

        // Random traffic with requesters holding requests until accepted
        p0v = 1'b0; p1v = 1'b0;
        p0r = '0; p1r = '0; p0d = '0; p1d = '0;
        for (int c = 0; c < 600; c++) begin
            if (!p0v && $urandom_range(0, 9) < 6) begin
                p0v = 1'b1;
                p0r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 9) < 5) begin
                p1v = 1'b1;
                p1r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                p1d = $urandom;
            end
            step($urandom_range(0, 63) != 0, p0v, p0r, p0d, p1v, p1r, p1d, gv, gid);
            if (gv && !gid) p0v = 1'b0;
            if (gv && gid) p1v = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
